dcache_bridge: RTL



---
 rtl/dcache_bridge_if.sv | 32 +++
 rtl/dcache_bridge.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dcache_bridge_if.sv
// rtl/dcache_bridge_if.sv - data-memory bus between dcache_bridge and the memory
// Signals:
//   mem_req    bus request, held until mem_ack
//   mem_we     1 = write
//   mem_addr   doubleword-aligned byte address
//   mem_wdata  write data already shifted to its byte lanes
//   mem_wstrb  byte enables, zero for reads
//   mem_ack    transfer completes; mem_rdata valid in the same cycle
//   mem_rdata  read data
// Modports: master (bridge side), slave (memory side).
interface dcache_bridge_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wstrb;
  logic                  mem_ack;
  logic [DATA_W-1:0]     mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/dcache_bridge.sv
// rtl/dcache_bridge.sv - load/store responder bridging the MEM stage to a 64-bit data bus
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   req_valid_i          EX/MEM holds a load or store this cycle
//   req_we_i             1 = store, 0 = load
//   req_addr_i           byte address
//   req_funct3_i         access size in [1:0] (B/H/W/D); bit 2 is used by MEM only
//   req_wdata_i          right-aligned store data
//   dcache_data_valid_o  result ready / nothing pending; MEM stalls while low
//   dcache_data_o        load data with the addressed bytes shifted down to bit 0
//   misalign_o           one-cycle pulse with valid for a misaligned access
//   mem_bus              data-memory bus (dcache_bridge_if.master)
// Optional feature: define DCACHE_LINEBUF_EN for a one-doubleword load buffer
// that serves repeat loads without a bus transfer.
module dcache_bridge #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid_i,
  input  logic                req_we_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [2:0]          req_funct3_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  output logic                dcache_data_valid_o,
  output logic [DATA_W-1:0]   dcache_data_o,
  output logic                misalign_o,
  dcache_bridge_if.master     mem_bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [7:0]          wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                misalign_q, misalign_d;

  // Request decode: byte offset, size mask, alignment.
  logic [2:0]          req_off;
  logic [1:0]          req_size;
  logic [7:0]          req_mask;
  logic                req_misaligned;
  logic [7:0]          req_wstrb;
  logic [DATA_W-1:0]   req_wdata_sh;
  logic                lookup_hit;

  assign req_off  = req_addr_i[2:0];
  assign req_size = req_funct3_i[1:0];

  // funct3[2] only selects sign/zero extension, which MEM does.
  logic unused_funct3_bit2;
  assign unused_funct3_bit2 = req_funct3_i[2];

  always_comb begin
    req_mask       = 8'h01;
    req_misaligned = 1'b0;
    case (req_size)
      2'd0: begin
        req_mask       = 8'h01;
        req_misaligned = 1'b0;
      end
      2'd1: begin
        req_mask       = 8'h03;
        req_misaligned = req_off[0];
      end
      2'd2: begin
        req_mask       = 8'h0F;
        req_misaligned = |req_off[1:0];
      end
      default: begin
        req_mask       = 8'hFF;
        req_misaligned = |req_off;
      end
    endcase
  end

  assign req_wstrb    = req_mask << req_off;
  assign req_wdata_sh = req_wdata_i << {req_off, 3'b000};

`ifdef DCACHE_LINEBUF_EN
  logic                buf_valid_q, buf_valid_d;
  logic [ADDR_W-4:0]   buf_tag_q, buf_tag_d;
  logic [DATA_W-1:0]   buf_data_q, buf_data_d;
  logic [DATA_W-1:0]   buf_rdata;

  // A load whose doubleword sits in the buffer completes in IDLE this cycle.
  assign lookup_hit = req_valid_i && !req_we_i && !req_misaligned && buf_valid_q &&
                      (buf_tag_q == req_addr_i[ADDR_W-1:3]);
  assign buf_rdata  = buf_data_q >> {req_off, 3'b000};

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;
    if (state_q == S_BUS && mem_bus.mem_ack) begin
      if (!we_q) begin
        buf_valid_d = 1'b1;
        buf_tag_d   = addr_q[ADDR_W-1:3];
        buf_data_d  = mem_bus.mem_rdata;
      end else if (buf_valid_q && buf_tag_q == addr_q[ADDR_W-1:3]) begin
        // Write-through: keep the buffered copy coherent with the store.
        for (int i = 0; i < 8; i++) begin
          if (wstrb_q[i]) begin
            buf_data_d[8*i +: 8] = wdata_q[8*i +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
    end
  end

  assign dcache_data_o = (state_q == S_IDLE && lookup_hit) ? buf_rdata : data_q;
`else
  assign lookup_hit    = 1'b0;
  assign dcache_data_o = data_q;
`endif

  always_comb begin
    state_d             = state_q;
    addr_d              = addr_q;
    we_d                = we_q;
    wdata_d             = wdata_q;
    wstrb_d             = wstrb_q;
    data_d              = data_q;
    misalign_d          = misalign_q;
    dcache_data_valid_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        dcache_data_valid_o = ~req_valid_i;
        if (req_valid_i) begin
          if (req_misaligned) begin
            misalign_d = 1'b1;
            data_d     = '0;
            state_d    = S_DONE;
          end else if (lookup_hit) begin
            dcache_data_valid_o = 1'b1;
          end else begin
            addr_d     = req_addr_i;
            we_d       = req_we_i;
            wdata_d    = req_wdata_sh;
            wstrb_d    = req_wstrb;
            misalign_d = 1'b0;
            state_d    = S_BUS;
          end
        end
      end
      S_BUS: begin
        if (mem_bus.mem_ack) begin
          data_d  = we_q ? '0 : (mem_bus.mem_rdata >> {addr_q[2:0], 3'b000});
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // The MEM stage consumes the result this cycle; req_valid_i is stale.
        dcache_data_valid_o = 1'b1;
        state_d             = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      data_q     <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      data_q     <= data_d;
      misalign_q <= misalign_d;
    end
  end

  // Bus outputs come straight from state, so the request drops as soon as
  // the ack moves the FSM on, and a reset clears them immediately.
  assign mem_bus.mem_req   = (state_q == S_BUS);
  assign mem_bus.mem_we    = (state_q == S_BUS) && we_q;
  assign mem_bus.mem_addr  = {addr_q[ADDR_W-1:3], 3'b000};
  assign mem_bus.mem_wdata = wdata_q;
  assign mem_bus.mem_wstrb = (state_q == S_BUS && we_q) ? wstrb_q : 8'h00;
  assign misalign_o        = (state_q == S_DONE) && misalign_q;

endmodule
